// File: rtl/gpu_loader_pkg.sv
// Shared definitions for the GPU program loader: state encoding,
// default buffer geometry and the counter-width helpers.
package gpu_loader_pkg;

   // Default buffer geometry.
   localparam int DEF_DATA_DEPTH = 1024;
   localparam int DEF_WORD_W     = 16;

   // Loader state encoding, kept as plain constants so older tools can read it.
   typedef logic [2:0] loader_state_t;
   localparam loader_state_t ST_IDLE = 3'd0;
   localparam loader_state_t ST_LOAD = 3'd1;
   localparam loader_state_t ST_FILL = 3'd2;
   localparam loader_state_t ST_HOLD = 3'd3;
   localparam loader_state_t ST_RUN  = 3'd4;

   // Width needed to count from 0 up to and including depth.
   function automatic int countWidth(input int depth);
      return $clog2(depth) + 1;
   endfunction

   // Width needed to address depth entries (never less than one bit).
   function automatic int addrWidth(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/frame_buf.sv
// Program frame buffer: DEPTH words of WIDTH bits, one write port,
// every word visible at once on the flat output bus.
module frame_buf #(
   parameter int DEPTH = 1024,
   parameter int WIDTH = 16,
   parameter int AW    = 10
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   we_i,
   input  logic [AW-1:0]          waddr_i,
   input  logic [WIDTH-1:0]       wdata_i,
   output logic [DEPTH*WIDTH-1:0] flat_o
);

   logic [DEPTH*WIDTH-1:0] buf_q;

   // Single-word write; reset wipes the whole program image.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         buf_q <= '0;
      end else if (we_i) begin
         buf_q[int'(waddr_i)*WIDTH +: WIDTH] <= wdata_i;
      end
   end

   assign flat_o = buf_q;

endmodule

// File: rtl/prog_loader.sv
// GPU program loader: accepts a stream of instruction words into the frame
// buffer, zero-fills the unused tail, holds the GPU in load mode for a few
// cycles and then releases it to run.
// Optional feature: define PROG_LOADER_CHECKSUM_EN to add a 'checksum'
// output carrying the XOR of all words accepted in the current load.
module prog_loader
   import gpu_loader_pkg::*;
#(
   parameter int DATA_DEPTH  = DEF_DATA_DEPTH,
   parameter int WORD_W      = DEF_WORD_W,
   parameter int HOLD_CYCLES = 4
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              start,
   input  logic                              wr_valid,
   input  logic [WORD_W-1:0]                 wr_data,
   input  logic                              wr_last,
   output logic                              wr_ready,
   output logic [DATA_DEPTH*WORD_W-1:0]      data_frames_in,
   output logic                              prog_loading,
   output logic                              frame_being_sent,
   output logic [countWidth(DATA_DEPTH)-1:0] word_count,
   output logic                              overflow
`ifdef PROG_LOADER_CHECKSUM_EN
   ,
   output logic [WORD_W-1:0]                 checksum
`endif
);

   localparam int CW = countWidth(DATA_DEPTH);
   localparam int AW = addrWidth(DATA_DEPTH);
   localparam int HW = countWidth(HOLD_CYCLES);

   localparam logic [CW-1:0] FULL_COUNT = CW'(DATA_DEPTH);
   localparam logic [CW-1:0] LAST_INDEX = CW'(DATA_DEPTH - 1);
   localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_CYCLES - 1);

   loader_state_t state_q, state_d;
   logic [CW-1:0] count_q, count_d;
   logic [CW-1:0] fillPtr_q, fillPtr_d;
   logic [HW-1:0] holdCnt_q, holdCnt_d;
   logic          loading_q, loading_d;
   logic          overflow_q, overflow_d;
`ifdef PROG_LOADER_CHECKSUM_EN
   logic [WORD_W-1:0] checksum_q, checksum_d;
`endif

   logic              bufWe;
   logic [AW-1:0]     bufAddr;
   logic [WORD_W-1:0] bufData;
   logic [CW-1:0]     countInc;

   assign countInc = count_q + CW'(1);

   // Next-state logic: the load sequence plus the buffer write port steering.
   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      fillPtr_d  = fillPtr_q;
      holdCnt_d  = holdCnt_q;
      loading_d  = loading_q;
      overflow_d = overflow_q;
`ifdef PROG_LOADER_CHECKSUM_EN
      checksum_d = checksum_q;
`endif
      bufWe   = 1'b0;
      bufAddr = count_q[AW-1:0];
      bufData = wr_data;

      // A word offered against a full buffer is lost; remember that.
      if (wr_valid && (count_q == FULL_COUNT)) begin
         overflow_d = 1'b1;
      end

      case (state_q)
         ST_IDLE, ST_RUN: begin
            if (start) begin
               state_d    = ST_LOAD;
               count_d    = '0;
               overflow_d = 1'b0;
               loading_d  = 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
               checksum_d = '0;
`endif
            end
         end
         ST_LOAD: begin
            if (wr_valid) begin
               bufWe   = 1'b1;
               count_d = countInc;
`ifdef PROG_LOADER_CHECKSUM_EN
               checksum_d = checksum_q ^ wr_data;
`endif
               if (countInc == FULL_COUNT) begin
                  state_d   = ST_HOLD;
                  holdCnt_d = '0;
               end else if (wr_last) begin
                  state_d   = ST_FILL;
                  fillPtr_d = countInc;
               end
            end
         end
         ST_FILL: begin
            bufWe   = 1'b1;
            bufAddr = fillPtr_q[AW-1:0];
            bufData = '0;
            if (fillPtr_q == LAST_INDEX) begin
               state_d   = ST_HOLD;
               holdCnt_d = '0;
            end else begin
               fillPtr_d = fillPtr_q + CW'(1);
            end
         end
         ST_HOLD: begin
            if (holdCnt_q == HOLD_LAST) begin
               state_d   = ST_RUN;
               loading_d = 1'b0;
            end else begin
               holdCnt_d = holdCnt_q + HW'(1);
            end
         end
         default: begin
            state_d   = ST_IDLE;
            loading_d = 1'b1;
         end
      endcase
   end

   // State registers; reset parks the loader in IDLE with the GPU held in load mode.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         count_q    <= '0;
         fillPtr_q  <= '0;
         holdCnt_q  <= '0;
         loading_q  <= 1'b1;
         overflow_q <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
         checksum_q <= '0;
`endif
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         fillPtr_q  <= fillPtr_d;
         holdCnt_q  <= holdCnt_d;
         loading_q  <= loading_d;
         overflow_q <= overflow_d;
`ifdef PROG_LOADER_CHECKSUM_EN
         checksum_q <= checksum_d;
`endif
      end
   end

   frame_buf #(
      .DEPTH (DATA_DEPTH),
      .WIDTH (WORD_W),
      .AW    (AW)
   ) u_frame_buf (
      .clk     (clk),
      .reset   (reset),
      .we_i    (bufWe),
      .waddr_i (bufAddr),
      .wdata_i (bufData),
      .flat_o  (data_frames_in)
   );

   assign wr_ready         = (state_q == ST_LOAD);
   assign frame_being_sent = (state_q == ST_LOAD) || (state_q == ST_FILL);
   assign prog_loading     = loading_q;
   assign word_count       = count_q;
   assign overflow         = overflow_q;
`ifdef PROG_LOADER_CHECKSUM_EN
   assign checksum         = checksum_q;
`endif

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: table-driven loads, randomized loads
// against a whole-buffer reference image, and hand-written corner sequences
// (overflow, reset mid-load / mid-fill, back-to-back loads, checksum).
`timescale 1ns/1ps
module tb_prog_loader;

   localparam int DEPTH = 1024;
   localparam int WW    = 16;
   localparam int HOLD  = 4;
   localparam int CW    = 11;

   logic                  clk = 1'b0;
   logic                  reset;
   logic                  start;
   logic                  wrValid;
   logic [WW-1:0]         wrData;
   logic                  wrLast;
   logic                  wrReady;
   logic [DEPTH*WW-1:0]   dataFrames;
   logic                  progLoading;
   logic                  frameBeingSent;
   logic [CW-1:0]         wordCount;
   logic                  overflow;
`ifdef PROG_LOADER_CHECKSUM_EN
   logic [WW-1:0]         checksum;
`endif

   int checks = 0;
   int errors = 0;

   // Reference model: the program image the GPU should see, plus load status.
   logic [WW-1:0] expMem [DEPTH];
   logic [WW-1:0] expXor;
   bit            loaded;

   typedef struct {
      int n;
      bit flagLast;
      bit poke;
      int base;
      int expCount;
      int expFill;
      int expFall;
   } vec_t;

   vec_t vecs[6];

   prog_loader #(
      .DATA_DEPTH  (DEPTH),
      .WORD_W      (WW),
      .HOLD_CYCLES (HOLD)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .start            (start),
      .wr_valid         (wrValid),
      .wr_data          (wrData),
      .wr_last          (wrLast),
      .wr_ready         (wrReady),
      .data_frames_in   (dataFrames),
      .prog_loading     (progLoading),
      .frame_being_sent (frameBeingSent),
      .word_count       (wordCount),
      .overflow         (overflow)
`ifdef PROG_LOADER_CHECKSUM_EN
      ,
      .checksum         (checksum)
`endif
   );

   // Free-running clock.
   always #5 clk = ~clk;

   function automatic logic [WW-1:0] getWord(input int j);
      return dataFrames[j*WW +: WW];
   endfunction

   task automatic checkOutput(input string name, input longint actual, input longint expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
      end
   endtask

   task automatic stepCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic checkBuffer(input string name);
      int bad = 0;
      for (int j = 0; j < DEPTH; j++) begin
         if (getWord(j) !== expMem[j]) bad++;
      end
      checkOutput(name, bad, 0);
   endtask

   task automatic clearModel();
      for (int j = 0; j < DEPTH; j++) expMem[j] = '0;
      expXor = '0;
      loaded = 1'b0;
   endtask

   // One complete load: start pulse, the given words, then wait for release.
   task automatic applyStimulus(input logic [WW-1:0] words[$], input bit flagLast,
                                input bit poke, input bit gaps,
                                output int fillCycles, output int fallCycles);
      int n = words.size();
      int k = 0;
      checkOutput("loading_before_start", progLoading, !loaded);
      start = 1'b1;
      stepCycle();
      start = 1'b0;
      checkOutput("count_after_start", wordCount, 0);
      checkOutput("overflow_after_start", overflow, 0);
      checkOutput("loading_after_start", progLoading, 1);
      checkOutput("ready_in_load", wrReady, 1);
      checkOutput("fbs_in_load", frameBeingSent, 1);
      expXor = '0;
      for (int i = 0; i < DEPTH; i++) expMem[i] = (i < n) ? words[i] : '0;
      for (int i = 0; i < n; i++) begin
         if (gaps && ($urandom_range(0, 3) == 0)) begin
            wrValid = 1'b0;
            stepCycle();
         end
         wrValid = 1'b1;
         wrData  = words[i];
         wrLast  = flagLast && (i == n - 1);
         start   = poke && (i == n / 2);
         expXor  = expXor ^ words[i];
         stepCycle();
         start   = 1'b0;
      end
      wrValid = 1'b0;
      wrLast  = 1'b0;
      fillCycles = 0;
      while (progLoading === 1'b1 && k < DEPTH + HOLD + 20) begin
         if (frameBeingSent === 1'b1) fillCycles++;
         start = poke && (k == 2);
         stepCycle();
         k++;
      end
      start = 1'b0;
      fallCycles = k;
      loaded = 1'b1;
      checkOutput("count_after_load", wordCount, n);
      checkOutput("overflow_after_load", overflow, 0);
      checkOutput("ready_in_run", wrReady, 0);
      checkBuffer("buffer_image");
`ifdef PROG_LOADER_CHECKSUM_EN
      checkOutput("checksum", checksum, expXor);
`endif
   endtask

   initial begin
      logic [WW-1:0] q[$];
      int fillC, fallC, n;
      bit fl;

      vecs[0] = '{n: 224,  flagLast: 1, poke: 0, base: 1,      expCount: 224,  expFill: 800,  expFall: 804};
      vecs[1] = '{n: 1024, flagLast: 0, poke: 0, base: 16'h100, expCount: 1024, expFill: 0,    expFall: 4};
      vecs[2] = '{n: 1,    flagLast: 1, poke: 0, base: 16'h7F0, expCount: 1,    expFill: 1023, expFall: 1027};
      vecs[3] = '{n: 1023, flagLast: 1, poke: 1, base: 16'h200, expCount: 1023, expFill: 1,    expFall: 5};
      vecs[4] = '{n: 10,   flagLast: 1, poke: 1, base: 16'h300, expCount: 10,   expFill: 1014, expFall: 1018};
      vecs[5] = '{n: 5,    flagLast: 1, poke: 0, base: 16'h400, expCount: 5,    expFill: 1019, expFall: 1023};

      reset = 1'b1; start = 1'b0; wrValid = 1'b0; wrData = '0; wrLast = 1'b0;
      clearModel();
      #12;
      checkOutput("reset_loading", progLoading, 1);
      checkOutput("reset_ready", wrReady, 0);
      checkOutput("reset_fbs", frameBeingSent, 0);
      checkOutput("reset_count", wordCount, 0);
      checkOutput("reset_overflow", overflow, 0);
      checkBuffer("reset_buffer");
      reset = 1'b0;
      stepCycle();
      checkOutput("idle_ignores_words", wrReady, 0);

      // Table-driven loads.
      for (int v = 0; v < 6; v++) begin
         q.delete();
         for (int i = 0; i < vecs[v].n; i++) q.push_back(WW'(vecs[v].base + i));
         applyStimulus(q, vecs[v].flagLast, vecs[v].poke, 1'b0, fillC, fallC);
         checkOutput($sformatf("vec%0d_count", v), wordCount, vecs[v].expCount);
         checkOutput($sformatf("vec%0d_fill_cycles", v), fillC, vecs[v].expFill);
         checkOutput($sformatf("vec%0d_fall_cycles", v), fallC, vecs[v].expFall);
      end
      checkOutput("second_load_word4", getWord(4), 16'h404);
      checkOutput("second_load_word7_zeroed", getWord(7), 0);

      // Full buffer, then keep offering words.
      q.delete();
      for (int i = 0; i < DEPTH; i++) q.push_back(WW'($urandom));
      applyStimulus(q, 1'b0, 1'b0, 1'b1, fillC, fallC);
      checkOutput("full_fill_skipped", fillC, 0);
      checkOutput("full_fall_cycles", fallC, HOLD);
      wrValid = 1'b1;
      wrData  = 16'hBEEF;
      stepCycle();
      checkOutput("overflow_set", overflow, 1);
      checkOutput("overflow_ready", wrReady, 0);
      stepCycle();
      wrValid = 1'b0;
      stepCycle();
      checkOutput("overflow_sticky", overflow, 1);
      checkOutput("overflow_word1023", getWord(DEPTH - 1), expMem[DEPTH - 1]);
      checkBuffer("overflow_buffer");

      // Randomized loads.
      for (int r = 0; r < 5; r++) begin
         n  = $urandom_range(1, DEPTH);
         fl = (n < DEPTH) ? 1'b1 : 1'($urandom_range(0, 1));
         q.delete();
         for (int i = 0; i < n; i++) q.push_back(WW'($urandom));
         applyStimulus(q, fl, 1'($urandom_range(0, 1)), 1'b1, fillC, fallC);
         checkOutput($sformatf("rand%0d_fill_cycles", r), fillC, DEPTH - n);
         checkOutput($sformatf("rand%0d_fall_cycles", r), fallC, DEPTH - n + HOLD);
      end

      // Reset in the middle of LOAD.
      start = 1'b1;
      stepCycle();
      start = 1'b0;
      for (int i = 0; i < 100; i++) begin
         wrValid = 1'b1;
         wrData  = WW'(16'hC000 + i);
         stepCycle();
      end
      checkOutput("midload_count", wordCount, 100);
      #2 reset = 1'b1;
      #1;
      clearModel();
      checkOutput("midload_reset_loading", progLoading, 1);
      checkOutput("midload_reset_ready", wrReady, 0);
      checkOutput("midload_reset_fbs", frameBeingSent, 0);
      checkOutput("midload_reset_count", wordCount, 0);
      checkOutput("midload_reset_overflow", overflow, 0);
      checkBuffer("midload_reset_buffer");
      wrValid = 1'b0;
      reset = 1'b0;
      stepCycle();

      // Reset in the middle of FILL.
      start = 1'b1;
      stepCycle();
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         wrValid = 1'b1;
         wrData  = WW'(16'hD000 + i);
         wrLast  = (i == 2);
         stepCycle();
      end
      wrValid = 1'b0;
      wrLast  = 1'b0;
      for (int i = 0; i < 5; i++) stepCycle();
      checkOutput("midfill_fbs", frameBeingSent, 1);
      checkOutput("midfill_word0", getWord(0), 16'hD000);
      #2 reset = 1'b1;
      #1;
      checkOutput("midfill_reset_fbs", frameBeingSent, 0);
      checkOutput("midfill_reset_count", wordCount, 0);
      checkBuffer("midfill_reset_buffer");
      reset = 1'b0;
      stepCycle();

`ifdef PROG_LOADER_CHECKSUM_EN
      q.delete();
      q.push_back(16'hA5A5);
      q.push_back(16'h0F0F);
      applyStimulus(q, 1'b1, 1'b0, 1'b0, fillC, fallC);
      checkOutput("checksum_known", checksum, 16'hAAAA);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 The block SHALL have parameter DATA_DEPTH, default 1024, giving the number of program words in the GPU frame buffer.
REQ-002 The block SHALL have parameter WORD_W, default 16, giving the instruction word width.
REQ-003 The block SHALL have parameter HOLD_CYCLES, default 4, giving the cycles prog_loading stays high after the buffer is complete.
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit, asynchronous active-high reset.
REQ-006 The block SHALL have port start, input, 1 bit, a one-cycle pulse that begins a new program load.
REQ-007 The block SHALL have port wr_valid, input, 1 bit, meaning the source presents a word.
REQ-008 The block SHALL have port wr_data, input, WORD_W bits, the instruction word.
REQ-009 The block SHALL have port wr_last, input, 1 bit, marking the final program word.
REQ-010 The block SHALL have port wr_ready, output, 1 bit, meaning the block accepts a word this cycle.
REQ-011 The block SHALL have port data_frames_in, output, DATA_DEPTH*WORD_W bits, the packed program buffer to gpu, word j at bits [j*WORD_W +: WORD_W].
REQ-012 The block SHALL have port prog_loading, output, 1 bit, which holds gpu in load mode while high.
REQ-013 The block SHALL have port frame_being_sent, output, 1 bit, high while words are being accepted or zero-filled.
REQ-014 The block SHALL have port word_count, output, clog2(DATA_DEPTH)+1 bits, the number of words accepted in the current load.
REQ-015 The block SHALL have port overflow, output, 1 bit, a sticky flag for a word offered with the buffer already full.

Function
REQ-016 The block SHALL implement the states IDLE, LOAD, FILL, HOLD and RUN.
REQ-017 In IDLE, a start pulse SHALL go to LOAD, clear word_count, clear overflow and keep prog_loading=1.
REQ-018 In LOAD, wr_ready SHALL be 1 and a word SHALL be written to index word_count on wr_valid&wr_ready, with word_count incremented.
REQ-019 An accepted word with wr_last=1, or an accepted word that makes word_count=DATA_DEPTH, SHALL end LOAD.
REQ-020 LOAD SHALL end in FILL if word_count<DATA_DEPTH, otherwise in HOLD.
REQ-021 FILL SHALL write zero to one index per cycle, from word_count up to DATA_DEPTH-1, with wr_ready=0, then go to HOLD.
REQ-022 FILL SHALL NOT change word_count.
REQ-023 HOLD SHALL keep prog_loading=1 for exactly HOLD_CYCLES cycles, then go to RUN.
REQ-024 On entering RUN, prog_loading SHALL fall to 0 in the same edge.
REQ-025 In RUN, a start pulse SHALL return to LOAD, with prog_loading back to 1 on the next edge.
REQ-026 Outside LOAD, wr_ready SHALL be 0 and offered words SHALL be ignored.
REQ-027 wr_valid while word_count=DATA_DEPTH SHALL set overflow, and overflow SHALL stay set until the next start or reset.
REQ-028 A start pulse during LOAD, FILL or HOLD SHALL be ignored.
REQ-029 frame_being_sent SHALL be 1 exactly in LOAD and FILL.
REQ-030 data_frames_in SHALL be registered and change only by the single-word writes above.

Reset
REQ-031 Reset SHALL force state=IDLE, prog_loading=1, wr_ready=0, frame_being_sent=0, word_count=0, overflow=0 and all data_frames_in bits to 0.
REQ-032 Reset asserted mid-LOAD or mid-FILL SHALL abort immediately, and the buffer SHALL read all-zero afterwards.

Configuration
REQ-033 With PROG_LOADER_CHECKSUM_EN defined, the block SHALL add output checksum (WORD_W bits), the XOR of all accepted words, cleared on start and reset and valid from HOLD onward.
REQ-034 Without PROG_LOADER_CHECKSUM_EN, the checksum port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-035 Package gpu_loader_pkg SHALL hold the state enum, the default DATA_DEPTH and WORD_W, and the count-width function.
REQ-036 One sub-module, frame_buf, SHALL hold the DATA_DEPTH x WORD_W register array with a single write port and the flat output.

Verification
REQ-037 Reset, then start, then 224 words 0x0001..0x00E0 with the last flagged: words 0..223 match, words 224..1023 = 0, word_count=224, prog_loading falls 4 cycles after FILL ends.
REQ-038 1024 words, none flagged last: FILL is skipped, HOLD is entered directly, and overflow=0.
REQ-039 Offer a 1025th word with wr_valid held after the buffer is full: overflow=1, wr_ready=0, word 1023 unchanged.
REQ-040 Assert reset after 100 words during LOAD: all outputs at reset values and the buffer all-zero.
REQ-041 Two successive loads from RUN, of 10 then 5 words: words 5..9 are zeroed and prog_loading goes 0->1->0.
REQ-042 With PROG_LOADER_CHECKSUM_EN, words 0xA5A5 and 0x0F0F give checksum = 0xAAAA.
